traffic_seq: RTL and testbench

- Traffic-light phase sequencer driven by the APB configuration registers of the traffic register block.
- Inputs: ctl_reg (4b), timer_0 (NS green duration), timer_1 (EW green duration).
- Outputs: one-hot lamp drives for the NS and EW approaches, plus a 2-bit status code for the stat_reg readback path.
- Owns all phase timing, pedestrian shortening and fault/flash handling.

---
 rtl/traffic_seq.sv | 142 ++++++++++++++
 tb/tb_traffic_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_seq.sv
// Traffic-light phase sequencer: NS/EW green-yellow-all-red cycle with
// pedestrian shortening, hold, yellow flash and enable override.
module traffic_seq #(
    parameter int unsigned YEL_CYC   = 8,
    parameter int unsigned AR_CYC    = 2,
    parameter int unsigned PED_MIN   = 4,
    parameter int unsigned FLASH_CYC = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [3:0]  ctl,
    input  logic [31:0] timer_0,
    input  logic [31:0] timer_1,
    input  logic        ped_req,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic [1:0]  stat,
    output logic        ped_pend
);

    typedef enum logic [2:0] {IDLE, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, FLASH} state_t;

    localparam logic [31:0] YEL_LD   = 32'(YEL_CYC - 1);
    localparam logic [31:0] AR_LD    = 32'(AR_CYC - 1);
    localparam logic [31:0] PED_LD   = 32'(PED_MIN - 1);
    localparam logic [31:0] FLASH_LD = 32'(FLASH_CYC - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ped_q, ped_d;
    logic        tog_q, tog_d;
    logic [2:0]  ns_q, ns_d, ew_q, ew_d;
    logic [1:0]  stat_q, stat_d;

    logic        en, flashReq, pedEn, hold, pedHit;
    logic [31:0] nsLoad, ewLoad;

    assign en       = ctl[0];
    assign flashReq = ctl[1];
    assign pedEn    = ctl[2];
    assign hold     = ctl[3];
    assign pedHit   = ped_req & pedEn;
    // A zero timer still yields a one-cycle green.
    assign nsLoad   = (timer_0 == 32'd0) ? 32'd0 : timer_0 - 32'd1;
    assign ewLoad   = (timer_1 == 32'd0) ? 32'd0 : timer_1 - 32'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        ped_d   = ped_q | pedHit;
        ns_d    = 3'b100;
        ew_d    = 3'b100;
        stat_d  = 2'd0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = 32'd0;
            tog_d   = 1'b0;
            ped_d   = 1'b0;
        end else if (flashReq && state_q != FLASH) begin
            state_d = FLASH;
            cnt_d   = FLASH_LD;
            tog_d   = 1'b1;
            ped_d   = 1'b0;
        end else if (state_q == FLASH) begin
            if (!flashReq) begin
                state_d = AR2;
                cnt_d   = AR_LD;
                ped_d   = pedHit;
            end else if (!hold) begin
                if (cnt_q == 32'd0) begin
                    tog_d = ~tog_q;
                    cnt_d = FLASH_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
        end else if (!hold) begin
            if (state_q == IDLE) begin
                state_d = NS_G;
                cnt_d   = nsLoad;
            end else if (cnt_q == 32'd0) begin
                // Entering an all-red phase services any pending request.
                case (state_q)
                    NS_G:    begin state_d = NS_Y; cnt_d = YEL_LD; end
                    NS_Y:    begin state_d = AR1;  cnt_d = AR_LD;  ped_d = pedHit; end
                    AR1:     begin state_d = EW_G; cnt_d = ewLoad; end
                    EW_G:    begin state_d = EW_Y; cnt_d = YEL_LD; end
                    EW_Y:    begin state_d = AR2;  cnt_d = AR_LD;  ped_d = pedHit; end
                    AR2:     begin state_d = NS_G; cnt_d = nsLoad; end
                    default: begin state_d = IDLE; cnt_d = 32'd0; end
                endcase
            end else if ((state_q == NS_G || state_q == EW_G) && ped_q && cnt_q > PED_LD) begin
                cnt_d = PED_LD;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end

        case (state_d)
            NS_G:    begin ns_d = 3'b001; stat_d = 2'd1; end
            NS_Y:    begin ns_d = 3'b010; stat_d = 2'd1; end
            AR1:     stat_d = 2'd1;
            EW_G:    begin ew_d = 3'b001; stat_d = 2'd2; end
            EW_Y:    begin ew_d = 3'b010; stat_d = 2'd2; end
            AR2:     stat_d = 2'd2;
            FLASH:   begin
                ns_d   = tog_d ? 3'b010 : 3'b000;
                ew_d   = tog_d ? 3'b010 : 3'b000;
                stat_d = 2'd3;
            end
            default: stat_d = 2'd0;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            ped_q   <= 1'b0;
            tog_q   <= 1'b0;
            ns_q    <= 3'b100;
            ew_q    <= 3'b100;
            stat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
            tog_q   <= tog_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            stat_q  <= stat_d;
        end
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign stat     = stat_q;
    assign ped_pend = ped_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Self-checking bench for traffic_seq: directed vector table, multi-cycle
// corner sequences and a randomized run against a phase/remaining-time model.
module tb_traffic_seq;

    localparam int unsigned YEL = 8, AR = 2, PMIN = 4, FCYC = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b0;
    logic [3:0]  ctl = 4'd0;
    logic [31:0] timer0 = 32'd0, timer1 = 32'd0;
    logic        pedReq = 1'b0;
    logic [2:0]  nsLight, ewLight;
    logic [1:0]  stat;
    logic        pedPend;

    int checks = 0;
    int errors = 0;

    traffic_seq #(.YEL_CYC(YEL), .AR_CYC(AR), .PED_MIN(PMIN), .FLASH_CYC(FCYC)) dut (
        .pclk(pclk), .preset(preset), .ctl(ctl), .timer_0(timer0), .timer_1(timer1),
        .ped_req(pedReq), .ns_light(nsLight), .ew_light(ewLight), .stat(stat), .ped_pend(pedPend)
    );

    always #5 pclk = ~pclk;

    // Outside flash at least one approach must show red, every cycle.
    always @(negedge pclk) begin
        if (!preset) begin
            checks++;
            if (stat != 2'd3 && nsLight != 3'b100 && ewLight != 3'b100) begin
                errors++;
                $display("[TB] FAIL redInvariant ns=%b ew=%b stat=%0d required one red", nsLight, ewLight, stat);
            end
        end
    end

    typedef struct {
        logic [3:0]  ctl;
        int unsigned t0, t1;
        int          edges;
        logic [2:0]  ns, ew;
        logic [1:0]  st;
        logic        pp;
    } vec_t;
    vec_t vecs[$];

    function automatic void addVec(logic [3:0] c, int unsigned a, int unsigned b, int e,
                                   logic [2:0] n, logic [2:0] w, logic [1:0] s);
        vec_t v;
        v.ctl = c; v.t0 = a; v.t1 = b; v.edges = e; v.ns = n; v.ew = w; v.st = s; v.pp = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [3:0] c, input int unsigned a, input int unsigned b,
                                 input logic req, input int edges);
        ctl = c; timer0 = a; timer1 = b; pedReq = req;
        repeat (edges) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eNs, input logic [2:0] eEw,
                               input logic [1:0] eSt, input logic ePp);
        checks++;
        if (nsLight !== eNs || ewLight !== eEw || stat !== eSt || pedPend !== ePp) begin
            errors++;
            $display("[TB] FAIL %s got ns=%b ew=%b stat=%0d ped=%b expected ns=%b ew=%b stat=%0d ped=%b",
                     name, nsLight, ewLight, stat, pedPend, eNs, eEw, eSt, ePp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitChange(input logic [2:0] nsNow, input int limit, output int n);
        n = 0;
        while (nsLight == nsNow && n < limit) begin
            @(posedge pclk);
            #1;
            n++;
        end
    endtask

    task automatic doReset();
        ctl = 4'd0; pedReq = 1'b0; timer0 = 32'd0; timer1 = 32'd0;
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
    endtask

    // Reference model: phase index 0..7 (IDLE,NSG,NSY,AR1,EWG,EWY,AR2,FLASH)
    // with the number of cycles still to spend in the current phase.
    int          mPhase, mRem, mFrem;
    logic        mTog, mPed;
    logic [2:0]  nsTab[8] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
    logic [2:0]  ewTab[8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010};
    logic [1:0]  stTab[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

    function automatic int phaseLen(int p);
        case (p)
            1:       return (timer0 == 0) ? 1 : int'(timer0);
            4:       return (timer1 == 0) ? 1 : int'(timer1);
            2, 5:    return YEL;
            default: return AR;
        endcase
    endfunction

    task automatic modelReset();
        mPhase = 0; mRem = 0; mFrem = 0; mTog = 1'b0; mPed = 1'b0;
    endtask

    task automatic modelStep();
        logic pedSet, pedOld;
        int   remOld;
        pedSet = pedReq & ctl[2];
        pedOld = mPed;
        if (!ctl[0]) begin
            mPhase = 0; mTog = 1'b0; mPed = 1'b0;
        end else if (ctl[1] && mPhase != 7) begin
            mPhase = 7; mTog = 1'b1; mFrem = FCYC; mPed = 1'b0;
        end else if (mPhase == 7) begin
            if (!ctl[1]) begin
                mPhase = 6; mRem = AR; mPed = pedSet;
            end else begin
                mPed = mPed | pedSet;
                if (!ctl[3]) begin
                    mFrem--;
                    if (mFrem == 0) begin mTog = ~mTog; mFrem = FCYC; end
                end
            end
        end else if (ctl[3]) begin
            mPed = mPed | pedSet;
        end else if (mPhase == 0) begin
            mPhase = 1; mRem = phaseLen(1); mPed = mPed | pedSet;
        end else begin
            remOld = mRem;
            mPed = mPed | pedSet;
            if (remOld == 1) begin
                mPhase = (mPhase == 6) ? 1 : mPhase + 1;
                mRem = phaseLen(mPhase);
                if (mPhase == 3 || mPhase == 6) mPed = pedSet;
            end else if ((mPhase == 1 || mPhase == 4) && pedOld && remOld > PMIN) begin
                mRem = PMIN;
            end else begin
                mRem = remOld - 1;
            end
        end
    endtask

    initial begin
        int n;
        logic fl, hd, pe;

        // Defaults: 5/3 greens -> 28-cycle period
        addVec(4'b0000, 5, 3, 0, 3'b100, 3'b100, 2'd0);
        addVec(4'b0001, 5, 3, 1, 3'b001, 3'b100, 2'd1);
        addVec(4'b0001, 5, 3, 4, 3'b001, 3'b100, 2'd1);
        addVec(4'b0001, 5, 3, 1, 3'b010, 3'b100, 2'd1);
        addVec(4'b0001, 5, 3, 7, 3'b010, 3'b100, 2'd1);
        addVec(4'b0001, 5, 3, 1, 3'b100, 3'b100, 2'd1);
        addVec(4'b0001, 5, 3, 1, 3'b100, 3'b100, 2'd1);
        addVec(4'b0001, 5, 3, 1, 3'b100, 3'b001, 2'd2);
        addVec(4'b0001, 5, 3, 2, 3'b100, 3'b001, 2'd2);
        addVec(4'b0001, 5, 3, 1, 3'b100, 3'b010, 2'd2);
        addVec(4'b0001, 5, 3, 7, 3'b100, 3'b010, 2'd2);
        addVec(4'b0001, 5, 3, 1, 3'b100, 3'b100, 2'd2);
        addVec(4'b0001, 5, 3, 1, 3'b100, 3'b100, 2'd2);
        addVec(4'b0001, 5, 3, 1, 3'b001, 3'b100, 2'd1);
        addVec(4'b0000, 5, 3, 1, 3'b100, 3'b100, 2'd0);
        // Zero timers -> one-cycle greens, 22-cycle period
        addVec(4'b0001, 0, 0, 1, 3'b001, 3'b100, 2'd1);
        addVec(4'b0001, 0, 0, 1, 3'b010, 3'b100, 2'd1);
        addVec(4'b0001, 0, 0, 8, 3'b100, 3'b100, 2'd1);
        addVec(4'b0001, 0, 0, 2, 3'b100, 3'b001, 2'd2);
        addVec(4'b0001, 0, 0, 1, 3'b100, 3'b010, 2'd2);
        addVec(4'b0001, 0, 0, 10, 3'b001, 3'b100, 2'd1);
        // Flash entered mid EW_G, toggling, then exit through AR2
        addVec(4'b0001, 1, 10, 1, 3'b010, 3'b100, 2'd1);
        addVec(4'b0001, 1, 10, 8, 3'b100, 3'b100, 2'd1);
        addVec(4'b0001, 1, 10, 2, 3'b100, 3'b001, 2'd2);
        addVec(4'b0001, 1, 10, 4, 3'b100, 3'b001, 2'd2);
        addVec(4'b0011, 1, 10, 1, 3'b010, 3'b010, 2'd3);
        addVec(4'b0011, 1, 10, 15, 3'b010, 3'b010, 2'd3);
        addVec(4'b0011, 1, 10, 1, 3'b000, 3'b000, 2'd3);
        addVec(4'b0011, 1, 10, 15, 3'b000, 3'b000, 2'd3);
        addVec(4'b0011, 1, 10, 1, 3'b010, 3'b010, 2'd3);
        addVec(4'b0001, 1, 10, 1, 3'b100, 3'b100, 2'd2);
        addVec(4'b0001, 1, 10, 1, 3'b100, 3'b100, 2'd2);
        addVec(4'b0001, 1, 10, 1, 3'b001, 3'b100, 2'd1);
        // en dropped mid EW_G -> IDLE on the next edge
        addVec(4'b0001, 1, 10, 1, 3'b010, 3'b100, 2'd1);
        addVec(4'b0001, 1, 10, 8, 3'b100, 3'b100, 2'd1);
        addVec(4'b0001, 1, 10, 5, 3'b100, 3'b001, 2'd2);
        addVec(4'b0000, 1, 10, 1, 3'b100, 3'b100, 2'd0);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ctl, vecs[i].t0, vecs[i].t1, 1'b0, vecs[i].edges);
            checkOutput($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ew, vecs[i].st, vecs[i].pp);
        end

        // Pedestrian request 10 cycles into a 100-cycle NS green
        doReset();
        applyStimulus(4'b0101, 100, 3, 1'b0, 11);
        applyStimulus(4'b0101, 100, 3, 1'b1, 1);
        checkOutput("pedLatched", 3'b001, 3'b100, 2'd1, 1'b1);
        pedReq = 1'b0;
        waitChange(3'b001, 200, n);
        checkCount("pedShortGreen", n, 5);
        checkOutput("pedHeldInYellow", 3'b010, 3'b100, 2'd1, 1'b1);
        applyStimulus(4'b0101, 100, 3, 1'b0, 8);
        checkOutput("pedClearedAr1", 3'b100, 3'b100, 2'd1, 1'b0);

        // Same request with ped_en low is ignored
        doReset();
        applyStimulus(4'b0001, 100, 3, 1'b0, 11);
        applyStimulus(4'b0001, 100, 3, 1'b1, 1);
        checkOutput("pedIgnored", 3'b001, 3'b100, 2'd1, 1'b0);
        pedReq = 1'b0;
        waitChange(3'b001, 200, n);
        checkCount("fullGreen", n, 89);

        // Hold for 7 cycles mid NS_Y stretches it from 8 to 15 cycles
        doReset();
        applyStimulus(4'b0001, 5, 3, 1'b0, 6);
        checkOutput("holdNsY", 3'b010, 3'b100, 2'd1, 1'b0);
        applyStimulus(4'b0001, 5, 3, 1'b0, 3);
        applyStimulus(4'b1001, 5, 3, 1'b0, 7);
        checkOutput("holdFrozen", 3'b010, 3'b100, 2'd1, 1'b0);
        ctl = 4'b0001;
        waitChange(3'b010, 50, n);
        checkCount("holdYellowLeft", n, 5);

        // Asynchronous reset mid NS_G, off the clock edge
        doReset();
        applyStimulus(4'b0001, 50, 3, 1'b0, 6);
        #3 preset = 1'b1;
        #1 checkOutput("asyncReset", 3'b100, 3'b100, 2'd0, 1'b0);
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk);
        #1 checkOutput("afterReset", 3'b001, 3'b100, 2'd1, 1'b0);

        // Randomized run against the phase model
        doReset();
        modelReset();
        fl = 1'b0; hd = 1'b0; pe = 1'b0;
        timer0 = 32'($urandom_range(0, 12));
        timer1 = 32'($urandom_range(0, 12));
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 2) fl = ~fl;
            if ($urandom_range(0, 99) < 5) hd = ~hd;
            if ($urandom_range(0, 99) < 5) pe = ~pe;
            if ($urandom_range(0, 99) < 2) timer0 = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 2) timer1 = 32'($urandom_range(0, 12));
            ctl = {hd, pe, fl, ($urandom_range(0, 99) < 98)};
            pedReq = ($urandom_range(0, 99) < 8);
            @(posedge pclk);
            #1;
            modelStep();
            checkOutput($sformatf("rand%0d", c),
                        (mPhase == 7 && !mTog) ? 3'b000 : nsTab[mPhase],
                        (mPhase == 7 && !mTog) ? 3'b000 : ewTab[mPhase],
                        stTab[mPhase], mPed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
